// File: rtl/logic_gates_pkg.sv
// Shared definitions for the gate-unit self-test sequencer: state
// encoding, vector count and counter widths.
package logic_gates_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int VEC_W       = 2;
  localparam int GATE_W      = 3;
  localparam int CNT_W       = 4;
  localparam int LOOP_W      = 8;

endpackage : logic_gates_pkg

// File: rtl/logic_gates_expect.sv
// Golden gate behaviour for one operand pair; purely combinational so it
// can sit next to the sequencer or be reused by a scoreboard.
module logic_gates_expect (
  input  logic a_i,
  input  logic b_i,
  output logic exp_and_o,
  output logic exp_or_o,
  output logic exp_not_o
);

  // Reference truth for the three gates under test.
  always_comb begin
    exp_and_o = a_i & b_i;
    exp_or_o  = a_i | b_i;
    exp_not_o = ~a_i;
  end

endmodule : logic_gates_expect

// File: rtl/logic_gates_seq.sv
// Self-test sequencer for the two-input gate unit. Walks the four operand
// vectors LOOPS times, waits SETTLE_CYCLES after each, samples the returned
// AND/OR/NOT values and accumulates sticky per-vector and per-gate errors.
module logic_gates_seq
  import logic_gates_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iAnd,
  input  logic              iOr,
  input  logic              iNot,
  output logic              oA,
  output logic              oB,
  output logic              oBusy,
  output logic              oDone,
  output logic              oPass,
  output logic [3:0]        oVecErr,
  output logic [GATE_W-1:0] oGateErr
);

  // Counters are sized for the legal ranges only, so reject anything else
  // at elaboration rather than let a counter silently wrap.
  generate
    if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15 || LOOPS < 1 || LOOPS > 255) begin : g_param_check
      $error("logic_gates_seq: SETTLE_CYCLES must be 0..15 and LOOPS 1..255");
    end
  endgenerate

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'(LOOPS - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST    = VEC_W'(NUM_VECTORS - 1);

  state_t                 state_q;
  logic [VEC_W-1:0]       vec_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [LOOP_W-1:0]      loop_q;
  logic                   a_q;
  logic                   b_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pass_q;
  logic [NUM_VECTORS-1:0] vec_err_q;
  logic [GATE_W-1:0]      gate_err_q;

  logic                   exp_and;
  logic                   exp_or;
  logic                   exp_not;
  logic [GATE_W-1:0]      mismatch_d;
  logic                   any_mismatch_d;
  logic [NUM_VECTORS-1:0] vec_hit_d;
  logic [NUM_VECTORS-1:0] vec_err_d;
  logic [GATE_W-1:0]      gate_err_d;
  logic [VEC_W-1:0]       vec_d;
  logic                   last_vec_d;
  logic                   last_loop_d;

  // Expected outputs follow the operands currently driven to the gate unit.
  logic_gates_expect u_expect (
    .a_i       (a_q),
    .b_i       (b_q),
    .exp_and_o (exp_and),
    .exp_or_o  (exp_or),
    .exp_not_o (exp_not)
  );

  // Per-gate compare of returned against expected values; only committed
  // to the sticky flags while in CHECK.
  always_comb begin
    mismatch_d     = {iAnd ^ exp_and, iOr ^ exp_or, iNot ^ exp_not};
    any_mismatch_d = |mismatch_d;
    gate_err_d     = gate_err_q | mismatch_d;
    vec_d          = vec_q + 1'b1;
    last_vec_d     = (vec_q == VEC_LAST);
    last_loop_d    = (loop_q == LOOP_LAST);
  end

  // One-hot select of the vector being checked, qualified by a mismatch.
  generate
    for (genvar gi = 0; gi < NUM_VECTORS; gi++) begin : g_vec_hit
      assign vec_hit_d[gi] = any_mismatch_d && (vec_q == VEC_W'(gi));
    end
  endgenerate

  assign vec_err_d = vec_err_q | vec_hit_d;

  // Sequencer FSM with counters, operand drive and registered result flags.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      loop_q     <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      vec_err_q  <= '0;
      gate_err_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          // DONE holds its results until a new start arrives.
          if (iStart) begin
            state_q    <= SETTLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            loop_q     <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            vec_err_q  <= '0;
            gate_err_q <= '0;
          end
        end

        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        CHECK: begin
          vec_err_q  <= vec_err_d;
          gate_err_q <= gate_err_d;
          cnt_q      <= '0;
          vec_q      <= vec_d;
          a_q        <= vec_d[1];
          b_q        <= vec_d[0];
          if (last_vec_d && last_loop_d) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= ~|gate_err_d;
          end else begin
            state_q <= SETTLE;
            if (last_vec_d) begin
              loop_q <= loop_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oA       = a_q;
  assign oB       = b_q;
  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign oPass    = pass_q;
  assign oVecErr  = vec_err_q;
  assign oGateErr = gate_err_q;

endmodule : logic_gates_seq

// File: tb/tb_logic_gates_seq.sv
// Bench for logic_gates_seq: two sequencer instances (default timing and a
// 3-loop / zero-settle build) each driving a modelled gate unit whose
// outputs can be corrupted per vector and glitched outside sample cycles.
module tb_logic_gates_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start2;
  logic       a1, b1, busy1, done1, pass1;
  logic       a2, b2, busy2, done2, pass2;
  logic [3:0] ve1, ve2;
  logic [2:0] ge1, ge2;
  logic [2:0] g1, g2;

  int tests = 0;
  int fails = 0;

  // Gate-unit model state: per-vector corruption {and,or,not} and glitches.
  logic [2:0] mask [4];
  logic [2:0] noise_bits;
  bit         noise_on;
  bit         running;
  int         run_j;
  int         per;
  logic       in_check;
  bit         sel;

  logic       obs_a, obs_b, obs_busy, obs_done, obs_pass;
  logic [3:0] obs_ve;
  logic [2:0] obs_ge;

  function automatic logic [2:0] gate_truth(input logic a, input logic b);
    return {a & b, a | b, ~a};
  endfunction

  // Faulty gate unit: true output, XOR a fixed per-vector fault, XOR
  // random glitches during cycles the sequencer must not be sampling.
  always_comb begin
    in_check = !running || ((run_j % per) == (per - 1));
    g1 = gate_truth(a1, b1) ^ mask[{a1, b1}] ^ ((noise_on && !in_check) ? noise_bits : 3'b000);
    g2 = gate_truth(a2, b2) ^ mask[{a2, b2}] ^ ((noise_on && !in_check) ? noise_bits : 3'b000);
  end

  always_comb begin
    obs_a    = sel ? a2    : a1;
    obs_b    = sel ? b2    : b1;
    obs_busy = sel ? busy2 : busy1;
    obs_done = sel ? done2 : done1;
    obs_pass = sel ? pass2 : pass1;
    obs_ve   = sel ? ve2   : ve1;
    obs_ge   = sel ? ge2   : ge1;
  end

  logic_gates_seq #(.SETTLE_CYCLES(2), .LOOPS(1)) u_dut1 (
    .iClk(clk), .iRst(rst), .iStart(start1),
    .iAnd(g1[2]), .iOr(g1[1]), .iNot(g1[0]),
    .oA(a1), .oB(b1), .oBusy(busy1), .oDone(done1), .oPass(pass1),
    .oVecErr(ve1), .oGateErr(ge1)
  );

  logic_gates_seq #(.SETTLE_CYCLES(0), .LOOPS(3)) u_dut2 (
    .iClk(clk), .iRst(rst), .iStart(start2),
    .iAnd(g2[2]), .iOr(g2[1]), .iNot(g2[0]),
    .oA(a2), .oB(b2), .oBusy(busy2), .oDone(done2), .oPass(pass2),
    .oVecErr(ve2), .oGateErr(ge2)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    noise_bits = 3'($urandom_range(7, 0));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ab"},   8'({obs_a, obs_b}), 8'd0);
    check({tag, "_busy"}, 8'(obs_busy), 8'd0);
    check({tag, "_done"}, 8'(obs_done), 8'd0);
    check({tag, "_pass"}, 8'(obs_pass), 8'd0);
    check({tag, "_ve"},   8'(obs_ve),   8'd0);
    check({tag, "_ge"},   8'(obs_ge),   8'd0);
  endtask

  // One complete run on the selected instance, checked against the
  // expected operand walk and the error summary implied by the fault table.
  task automatic run_check(input bit s, input int loops, input int settle,
                           input bit noisy, input bit strobes, input string tag);
    int p, total, idx;
    logic [3:0] exp_ve;
    logic [2:0] exp_ge;
    p = settle + 2;
    total = 4 * loops * p;
    exp_ve = '0;
    exp_ge = '0;
    for (int v = 0; v < 4; v++) begin
      exp_ve[v] = |mask[v];
      exp_ge    = exp_ge | mask[v];
    end
    sel = s;
    per = p;
    noise_on = noisy;
    if (s) start2 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
    running = 1'b1;
    run_j = 0;
    check({tag, "_start_done"}, 8'(obs_done), 8'd0);
    check({tag, "_start_pass"}, 8'(obs_pass), 8'd0);
    check({tag, "_start_ve"},   8'(obs_ve),   8'd0);
    check({tag, "_start_ge"},   8'(obs_ge),   8'd0);
    for (int n = 0; n < total; n++) begin
      idx = (n / p) % 4;
      check({tag, "_ab"},   8'({obs_a, obs_b}), 8'(idx));
      check({tag, "_busy"}, 8'(obs_busy), 8'd1);
      check({tag, "_done"}, 8'(obs_done), 8'd0);
      if (strobes && n < total - 1 && $urandom_range(3, 0) == 0) begin
        if (s) start2 = 1'b1; else start1 = 1'b1;
      end
      tick();
      start1 = 1'b0;
      start2 = 1'b0;
      run_j = n + 1;
    end
    running = 1'b0;
    noise_on = 1'b0;
    check({tag, "_end_done"}, 8'(obs_done), 8'd1);
    check({tag, "_end_busy"}, 8'(obs_busy), 8'd0);
    check({tag, "_end_pass"}, 8'(obs_pass), 8'(exp_ve == 4'd0));
    check({tag, "_end_ve"},   8'(obs_ve),   8'(exp_ve));
    check({tag, "_end_ge"},   8'(obs_ge),   8'(exp_ge));
    $display("[TB] run %s dut%0d loops=%0d settle=%0d ve=%b ge=%b pass=%0b",
             tag, s ? 2 : 1, loops, settle, obs_ve, obs_ge, obs_pass);
  endtask

  task automatic clear_mask();
    for (int v = 0; v < 4; v++) mask[v] = 3'b000;
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    noise_on = 1'b0;
    running = 1'b0;
    run_j = 0;
    per = 4;
    sel = 1'b0;
    noise_bits = 3'b000;
    clear_mask();
    tick();
    tick();
    sel = 1'b0; check_idle_zero("reset1");
    sel = 1'b1; check_idle_zero("reset2");
    rst = 1'b0;

    // Healthy gate unit, default timing.
    clear_mask();
    run_check(1'b0, 1, 2, 1'b0, 1'b0, "good");

    // OR stuck at 0: wrong whenever A|B is 1.
    clear_mask();
    for (int v = 1; v < 4; v++) mask[v] = 3'b010;
    run_check(1'b0, 1, 2, 1'b0, 1'b0, "or_sa0");

    // NOT returns A: always wrong; 3 loops, no settle.
    clear_mask();
    for (int v = 0; v < 4; v++) mask[v] = 3'b001;
    run_check(1'b1, 3, 0, 1'b0, 1'b0, "not_inv");

    // Restart from DONE with busy-time start pulses that must be ignored.
    clear_mask();
    run_check(1'b0, 1, 2, 1'b0, 1'b1, "restart");

    // Reset mid-run aborts and clears everything.
    sel = 1'b0;
    per = 4;
    mask[2] = 3'b100;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 0; n < 7; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("midrst");
    tick();
    check("midrst_idle_busy", 8'(obs_busy), 8'd0);
    clear_mask();
    run_check(1'b0, 1, 2, 1'b0, 1'b0, "after_rst");

    // Start held high: DONE pulses at edges 16 and 33, operands restart at 00.
    sel = 1'b0;
    start1 = 1'b1;
    for (int e = 0; e < 40; e++) begin
      tick();
      check("held_done", 8'(obs_done), 8'((e == 16) || (e == 33)));
      check("held_busy", 8'(obs_busy), 8'(!((e == 16) || (e == 33))));
      if (e == 17 || e == 34) check("held_ab00", 8'({obs_a, obs_b}), 8'd0);
    end
    start1 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("held_rst");

    // Random fault tables, glitches and ignored start pulses on both builds.
    for (int r = 0; r < 8; r++) begin
      bit s;
      clear_mask();
      if (r % 3 != 0) begin
        for (int v = 0; v < 4; v++)
          mask[v] = ($urandom_range(1, 0) == 1) ? 3'($urandom_range(7, 1)) : 3'b000;
      end
      s = 1'($urandom_range(1, 0));
      if (s) run_check(1'b1, 3, 0, 1'b1, 1'b1, "rand");
      else   run_check(1'b0, 1, 2, 1'b1, 1'b1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_logic_gates_seq

// File: doc/logic_gates_seq.md
Name: logic_gates_seq

Overview:
- Self-test sequencer for the two-input gate unit (AND/OR/NOT outputs).
- Drives all four input vectors (iA,iB = 00,01,10,11) onto the gate unit and waits a programmable settle time.
- Samples the gate outputs, compares them against internally generated expected values, and reports a pass/fail summary.
- Sits beside the gate unit on the lab board top level. Start comes from a debounced button; results go to LEDs.

Parameters:
- SETTLE_CYCLES, 2, number of idle cycles between driving a vector and sampling the outputs (0..15 legal).
- LOOPS, 1, number of full 4-vector passes per run (1..255 legal).

Ports:
- iClk  input  1  system clock, all logic on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iStart  input  1  run request, sampled every cycle; acted on only in IDLE or DONE.
- iAnd  input  1  AND output returned from the gate unit.
- iOr  input  1  OR output returned from the gate unit.
- iNot  input  1  NOT output returned from the gate unit.
- oA  output  1  A operand driven to the gate unit, registered.
- oB  output  1  B operand driven to the gate unit, registered.
- oBusy  output  1  high while in SETTLE or CHECK.
- oDone  output  1  high in DONE; level, held until the next start or reset.
- oPass  output  1  high in DONE when no mismatch was seen during the run.
- oVecErr  output  4  bit v set if vector v (v = {A,B}) mismatched in any loop; sticky within a run.
- oGateErr  output  3  {and,or,not} sticky per-gate mismatch flags for the run.

Behaviour:
- Reset (iRst=1 at an edge, from any state):
  - state goes to IDLE.
  - oA=0, oB=0, oBusy=0, oDone=0, oPass=0, oVecErr=0, oGateErr=0.
  - vector index, settle counter and loop counter all cleared.
  - Reset mid-run aborts the run with no partial results kept.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE with iStart=1:
  - next state SETTLE.
  - vec=0, oA=0, oB=0, cnt=0, loop=0.
  - oVecErr, oGateErr, oDone and oPass cleared on the same edge.
- iStart while busy (SETTLE or CHECK) is ignored.
- SETTLE:
  - if cnt==SETTLE_CYCLES, next state CHECK.
  - otherwise cnt+1 and stay in SETTLE.
  - oA/oB are held stable.
- CHECK (exactly one cycle):
  - Expected values: expAnd = A&B, expOr = A|B, expNot = ~A.
  - Any mismatch sets oVecErr[vec] and the matching oGateErr bit(s). Flags OR-accumulate and are never cleared mid-run.
  - If vec==3 and loop==LOOPS-1: next state DONE, oDone=1, oPass = ~|(accumulated error including this cycle).
  - Else if vec==3: loop+1, vec=0.
  - Else: vec+1.
  - oA/oB take the new vec's bits on the same edge; cnt=0; next state SETTLE.
- Timing:
  - Each vector takes SETTLE_CYCLES+2 cycles.
  - oDone rises 4*LOOPS*(SETTLE_CYCLES+2) rising edges after the edge that accepted iStart.
  - With default parameters that is 16 edges.
- Inputs iAnd/iOr/iNot are sampled only in CHECK; values in any other state have no effect.
- iStart held high continuously restarts the run on the cycle after DONE is entered (DONE lasts one cycle).
- Counter widths: cnt 4 bits, loop 8 bits, vec 2 bits. No wrap occurs within legal parameter ranges.
- Out-of-range parameters are a static elaboration error (guarded by a generate check).

Decomposition:
- Shared package logic_gates_pkg holds:
  - state encoding constants: IDLE=2'd0, SETTLE=2'd1, CHECK=2'd2, DONE=2'd3.
  - NUM_VECTORS=4.
  - counter width constants CNT_W=4 and LOOP_W=8.
- One natural sub-module, logic_gates_expect: combinational, takes A and B, produces expAnd/expOr/expNot. Reusable by the bench scoreboard.
- FSM, counters and error accumulation stay in logic_gates_seq.

Test Plan:
- Correct gate unit attached, defaults, pulse iStart at cycle 0 -> oBusy high cycles 1-16; oA,oB step 00,01,10,11 every 4 cycles; oDone=1 and oPass=1 at edge 16; oVecErr=0000; oGateErr=000.
- Gate unit with OR stuck-at-0 -> oDone at edge 16; oPass=0; oVecErr=1110; oGateErr=010.
- NOT output inverted (returns A), LOOPS=3, SETTLE_CYCLES=0 -> oDone at edge 24; oVecErr=1111; oGateErr=001.
- iRst asserted at cycle 7 mid-run -> next edge all outputs 0 and state IDLE; new iStart gives a full 16-cycle run with oPass=1.
- iStart pulsed at cycles 3 and 9 during a run -> ignored; oDone still at edge 16. Then iStart while DONE -> flags clear on that edge and a new run begins.
- iStart held high for 40 cycles, defaults -> DONE is a one-cycle pulse at edges 16 and 33; oA/oB return to 00 the edge after each DONE.
